// File: rtl/if_stage_if.sv
// Fetch-stage bus: pipeline control inputs, instruction-memory port and IF/ID register outputs.
interface if_stage_if;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst_in;
  logic        imem_ready;
  logic [31:0] PC_out;
  logic [31:0] IF_ID_inst;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_pc_4;
  logic        IF_ID_valid;

  modport master (
    output stall, flush, redirect, redirect_pc, inst_in, imem_ready,
    input  PC_out, IF_ID_inst, IF_ID_pc, IF_ID_pc_4, IF_ID_valid
  );

  modport slave (
    input  stall, flush, redirect, redirect_pc, inst_in, imem_ready,
    output PC_out, IF_ID_inst, IF_ID_pc, IF_ID_pc_4, IF_ID_valid
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a one-entry skid buffer
// that captures a word returned by memory while decode is stalled.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic    clk,
  input  logic    reset,
  if_stage_if.slave bus
);

  typedef enum logic {FETCH, BUFFERED} state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic        valid;
  } ifid_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } skid_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  skid_t       skid_q, skid_d;

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    skid_d  = skid_q;

    if (bus.redirect) begin
      pc_d    = bus.redirect_pc & ALIGN_MASK;
      state_d = FETCH;
      skid_d  = '0;
      if (!bus.stall || bus.flush) begin
        ifid_d.valid = 1'b0;
        ifid_d.inst  = NOP_INST;
      end
    end else if (bus.flush) begin
      // A squashed buffered word was never consumed, so fetch restarts at its address.
      if (state_q == BUFFERED) pc_d = skid_q.pc;
      state_d      = FETCH;
      skid_d       = '0;
      ifid_d.valid = 1'b0;
      ifid_d.inst  = NOP_INST;
    end else if (state_q == BUFFERED) begin
      if (!bus.stall) begin
        ifid_d  = ifid_t'{inst: skid_q.inst, pc: skid_q.pc,
                          pc_4: skid_q.pc + 32'd4, valid: 1'b1};
        pc_d    = skid_q.pc + 32'd4;
        state_d = FETCH;
      end
    end else if (bus.imem_ready) begin
      if (bus.stall) begin
        skid_d  = skid_t'{inst: bus.inst_in, pc: pc_q};
        state_d = BUFFERED;
      end else begin
        ifid_d = ifid_t'{inst: bus.inst_in, pc: pc_q, pc_4: pc_q + 32'd4, valid: 1'b1};
        pc_d   = pc_q + 32'd4;
      end
    end else if (!bus.stall) begin
      ifid_d.valid = 1'b0;
      ifid_d.inst  = NOP_INST;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC & ALIGN_MASK;
      ifid_q  <= ifid_t'{inst: NOP_INST, pc: 32'd0, pc_4: 32'd0, valid: 1'b0};
      // NOTE: the skid entry is reset too; it is never read outside BUFFERED, but a known value keeps sims clean.
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.PC_out      = pc_q;
  assign bus.IF_ID_inst  = ifid_q.inst;
  assign bus.IF_ID_pc    = ifid_q.pc;
  assign bus.IF_ID_pc_4  = ifid_q.pc_4;
  assign bus.IF_ID_valid = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a directed vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model of the fetch rules.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, flush, redirect, rdy;
    logic [31:0] rpc, inst;
    logic [31:0] e_pc, e_inst, e_ipc, e_ipc4;
    logic        e_valid;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } word_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                           input logic [31:0] ipc, input logic [31:0] ipc4, input logic valid);
    check({tag, ".PC_out"},      bus.PC_out,      pc);
    check({tag, ".IF_ID_inst"},  bus.IF_ID_inst,  inst);
    check({tag, ".IF_ID_pc"},    bus.IF_ID_pc,    ipc);
    check({tag, ".IF_ID_pc_4"},  bus.IF_ID_pc_4,  ipc4);
    check({tag, ".IF_ID_valid"}, {31'd0, bus.IF_ID_valid}, {31'd0, valid});
  endtask

  task automatic drive(input logic st, input logic fl, input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic [31:0] inst);
    bus.stall       = st;
    bus.flush       = fl;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.imem_ready  = rdy;
    bus.inst_in     = inst;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cycle();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic st, input logic fl, input logic rd, input logic [31:0] rpc,
                              input logic rdy, input logic [31:0] inst, input logic [31:0] e_pc,
                              input logic [31:0] e_inst, input logic [31:0] e_ipc, input logic e_valid);
    vec_t v;
    v.stall = st; v.flush = fl; v.redirect = rd; v.rpc = rpc; v.rdy = rdy; v.inst = inst;
    v.e_pc = e_pc; v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_ipc4 = e_ipc + 32'd4; v.e_valid = e_valid;
    return v;
  endfunction

  // Reference model state
  logic [31:0] m_pc, m_inst, m_ipc, m_ipc4;
  logic        m_valid;
  word_t       held[$];

  task automatic model_step(input logic rst, input logic st, input logic fl, input logic rd,
                            input logic [31:0] rpc, input logic rdy, input logic [31:0] inst);
    word_t w;
    if (rst) begin
      m_pc = 32'd0; m_inst = NOP; m_ipc = 32'd0; m_ipc4 = 32'd0; m_valid = 1'b0;
      held.delete();
    end else if (rd) begin
      if (!st || fl) begin m_valid = 1'b0; m_inst = NOP; end
      held.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else if (fl) begin
      m_valid = 1'b0; m_inst = NOP;
      if (held.size() > 0) m_pc = held[0].pc;
      held.delete();
    end else if (held.size() > 0) begin
      if (!st) begin
        w = held.pop_front();
        m_inst = w.inst; m_ipc = w.pc; m_ipc4 = w.pc + 32'd4; m_valid = 1'b1;
        m_pc = w.pc + 32'd4;
      end
    end else if (rdy) begin
      if (st) begin
        w.inst = inst; w.pc = m_pc;
        held.push_back(w);
      end else begin
        m_inst = inst; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end else if (!st) begin
      m_valid = 1'b0; m_inst = NOP;
    end
  endtask

  vec_t tbl[17];

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

    // Streaming, skid, wait states, redirect and flush walked through as one table after reset
    //            st fl rd rpc           rdy inst           e_pc   e_inst         e_ipc  valid
    tbl[0]  = mk(0, 0, 0, 32'h0,       1, 32'h1000_0000, 32'h04, 32'h1000_0000, 32'h00, 1);
    tbl[1]  = mk(0, 0, 0, 32'h0,       1, 32'h1000_0004, 32'h08, 32'h1000_0004, 32'h04, 1);
    tbl[2]  = mk(0, 0, 0, 32'h0,       1, 32'h1000_0008, 32'h0C, 32'h1000_0008, 32'h08, 1);
    tbl[3]  = mk(0, 0, 0, 32'h0,       1, 32'h1000_000C, 32'h10, 32'h1000_000C, 32'h0C, 1);
    tbl[4]  = mk(1, 0, 0, 32'h0,       1, 32'h8C01_0004, 32'h10, 32'h1000_000C, 32'h0C, 1);
    tbl[5]  = mk(1, 0, 0, 32'h0,       0, 32'h5555_5555, 32'h10, 32'h1000_000C, 32'h0C, 1);
    tbl[6]  = mk(0, 0, 0, 32'h0,       0, 32'h6666_6666, 32'h14, 32'h8C01_0004, 32'h10, 1);
    tbl[7]  = mk(0, 0, 0, 32'h0,       0, 32'h7777_7777, 32'h14, NOP,           32'h10, 0);
    tbl[8]  = mk(0, 0, 1, 32'h23,      1, 32'hBAD0_0000, 32'h20, NOP,           32'h10, 0);
    tbl[9]  = mk(0, 0, 0, 32'h0,       0, 32'h0,         32'h20, NOP,           32'h10, 0);
    tbl[10] = mk(0, 0, 0, 32'h0,       0, 32'h0,         32'h20, NOP,           32'h10, 0);
    tbl[11] = mk(0, 0, 0, 32'h0,       1, 32'h1000_0020, 32'h24, 32'h1000_0020, 32'h20, 1);
    tbl[12] = mk(0, 1, 0, 32'h0,       1, 32'hDEAD_BEEF, 32'h24, NOP,           32'h20, 0);
    tbl[13] = mk(1, 0, 0, 32'h0,       1, 32'hAAAA_0024, 32'h24, NOP,           32'h20, 0);
    tbl[14] = mk(1, 1, 0, 32'h0,       0, 32'h0,         32'h24, NOP,           32'h20, 0);
    tbl[15] = mk(0, 0, 0, 32'h0,       1, 32'h1000_0024, 32'h28, 32'h1000_0024, 32'h24, 1);
    tbl[16] = mk(1, 0, 1, 32'h40,      1, 32'hBAD0_0001, 32'h40, 32'h1000_0024, 32'h24, 1);

    do_reset();
    check_all("reset", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].stall, tbl[i].flush, tbl[i].redirect, tbl[i].rpc, tbl[i].rdy, tbl[i].inst);
      cycle();
      check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_ipc,
                tbl[i].e_ipc4, tbl[i].e_valid);
    end

    // Skid at PC 8: three stalled cycles, then release with memory idle
    do_reset();
    drive(0, 0, 0, 32'h0, 1, 32'h1000_0000); cycle();
    drive(0, 0, 0, 32'h0, 1, 32'h1000_0004); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 32'h0, 1, 32'h8C01_0004); cycle();
      check_all($sformatf("skid_hold%0d", i), 32'h08, 32'h1000_0004, 32'h04, 32'h08, 1'b1);
    end
    drive(0, 0, 0, 32'h0, 0, 32'h0); cycle();
    check_all("skid_release", 32'h0C, 32'h8C01_0004, 32'h08, 32'h0C, 1'b1);

    // Redirect while buffered: the buffered word must never surface
    drive(1, 0, 0, 32'h0, 1, 32'hCAFE_000C); cycle();
    drive(0, 0, 1, 32'h0000_0103, 1, 32'hCAFE_000C); cycle();
    check_all("redir_buf", 32'h100, NOP, 32'h08, 32'h0C, 1'b0);
    drive(0, 0, 0, 32'h0, 0, 32'h0); cycle();
    check_all("redir_idle", 32'h100, NOP, 32'h08, 32'h0C, 1'b0);
    drive(0, 0, 0, 32'h0, 1, 32'h1000_0100); cycle();
    check_all("redir_fetch", 32'h104, 32'h1000_0100, 32'h100, 32'h104, 1'b1);

    // Wrap at the top of the address space, then reset overriding everything mid-BUFFERED
    drive(0, 0, 1, 32'hFFFF_FFFF, 0, 32'h0); cycle();
    check("wrap_pc_aligned", bus.PC_out, 32'hFFFF_FFFC);
    drive(0, 0, 0, 32'h0, 1, 32'h1FFF_FFFC); cycle();
    check_all("wrap", 32'h0, 32'h1FFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1);
    drive(1, 0, 0, 32'h0, 1, 32'h2222_0000); cycle();
    reset = 1'b1;
    drive(1, 1, 1, 32'h0000_0200, 1, 32'h3333_0000); cycle();
    reset = 1'b0;
    check_all("reset_override", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
    drive(0, 0, 0, 32'h0, 0, 32'h0); cycle();
    check_all("reset_no_buf", 32'h0, NOP, 32'h0, 32'h0, 1'b0);

    // Randomized run against the reference model
    model_step(1'b1, 0, 0, 0, 32'h0, 0, 32'h0);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst, r_st, r_fl, r_rd, r_rdy;
      logic [31:0] r_rpc, r_inst;
      r_rst  = ($urandom_range(0, 99) < 1);
      r_st   = ($urandom_range(0, 99) < 35);
      r_fl   = ($urandom_range(0, 99) < 6);
      r_rd   = ($urandom_range(0, 99) < 6);
      r_rdy  = ($urandom_range(0, 99) < 70);
      r_rpc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      r_inst = $urandom;
      reset  = r_rst;
      drive(r_st, r_fl, r_rd, r_rpc, r_rdy, r_inst);
      model_step(r_rst, r_st, r_fl, r_rd, r_rpc, r_rdy, r_inst);
      cycle();
      check_all($sformatf("rand%0d", i), m_pc, m_inst, m_ipc, m_ipc4, m_valid);
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0000, is the instruction word for a bubble.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  decode hazard: hold IF/ID and PC.
REQ-006 flush  input  1  squash: IF/ID becomes a bubble.
REQ-007 redirect  input  1  branch/jump taken: load PC from redirect_pc.
REQ-008 redirect_pc  input  32  branch/jump target.
REQ-009 inst_in  input  32  instruction memory data; valid only when imem_ready=1.
REQ-010 imem_ready  input  1  inst_in holds the word at the current PC_out.
REQ-011 PC_out  output  32  fetch address driven to instruction memory.
REQ-012 IF_ID_inst  output  32  registered instruction for decode.
REQ-013 IF_ID_pc  output  32  registered address of IF_ID_inst.
REQ-014 IF_ID_pc_4  output  32  registered IF_ID_pc+4, used for jal link.
REQ-015 IF_ID_valid  output  1  IF_ID_inst is a real instruction, not a bubble.

Function
REQ-016 State machine states: FETCH and BUFFERED; one-entry skid buffer holds buf_inst and buf_pc.
REQ-017 Per-edge priority: reset > redirect > flush > stall > normal.
REQ-018 FETCH, imem_ready=1, stall=0: IF/ID <= {inst_in, PC_out, PC_out+4, valid 1}; PC_out <= PC_out+4.
REQ-019 FETCH, imem_ready=1, stall=1: IF/ID holds; buf <= {inst_in, PC_out}; PC_out holds; go to BUFFERED.
REQ-020 FETCH, imem_ready=0, stall=0: IF_ID_valid <= 0, IF_ID_inst <= NOP_INST; PC_out holds.
REQ-021 FETCH, imem_ready=0, stall=1: IF/ID and PC_out hold.
REQ-022 BUFFERED: imem_ready and inst_in are ignored.
REQ-023 BUFFERED, stall=0: IF/ID <= {buf_inst, buf_pc, buf_pc+4, valid 1}; PC_out <= buf_pc+4; go to FETCH.
REQ-024 BUFFERED, stall=1: IF/ID, buf and PC_out hold.
REQ-025 Throughput: with stall=0 and imem_ready=1 every cycle, one instruction per cycle; fetch-to-IF/ID latency is 1 cycle.
REQ-026 redirect=1, any state: PC_out <= {redirect_pc[31:2],2'b00}; buf discarded; state <= FETCH; any inst_in this cycle is discarded.
REQ-027 redirect=1 with stall=0 or flush=1: IF/ID becomes a bubble (valid 0, inst NOP_INST).
REQ-028 redirect=1 with stall=1 and flush=0: IF/ID holds.
REQ-029 flush=1, redirect=0: IF/ID becomes a bubble; buf discarded; state <= FETCH.
REQ-030 flush=1, redirect=0: PC_out <= buf_pc if state was BUFFERED, else PC_out holds; inst_in this cycle is discarded.
REQ-031 Address arithmetic is modulo 2^32: PC 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-032 PC_out[1:0] is always 2'b00.
REQ-033 A bubble carries IF_ID_pc and IF_ID_pc_4 unchanged from the previous IF/ID contents.
REQ-034 There are no combinational paths from any input to any output; all outputs are registered.

Reset
REQ-035 reset=1 at an edge: PC_out <= RESET_PC, IF_ID_inst <= NOP_INST, IF_ID_pc <= 0, IF_ID_pc_4 <= 0, IF_ID_valid <= 0, state <= FETCH, buf cleared.
REQ-036 reset overrides redirect, flush, stall and imem_ready in the same cycle, including when asserted mid-BUFFERED.
REQ-037 The first fetch after reset release is from RESET_PC.

Verification
REQ-038 Streaming: reset, imem_ready=1 with inst_in=PC-dependent words for 4 cycles -> IF_ID_pc 0,4,8,C on consecutive cycles, valid=1, PC_out=10.
REQ-039 Skid: PC_out=8, imem_ready=1, inst_in=0x8C01_0004, stall=1 for 3 cycles -> PC_out stays 8 and IF/ID holds; on stall=0, IF_ID_inst=0x8C01_0004, IF_ID_pc=8, PC_out=C, no imem access needed.
REQ-040 Redirect: redirect=1, redirect_pc=0x0000_0103 while BUFFERED -> PC_out=0x100, IF_ID_valid=0, buffered word never appears on IF/ID.
REQ-041 Wait states: imem_ready=0 for 2 cycles at PC_out=0x20 -> IF_ID_valid=0 both cycles and PC_out=0x20; then imem_ready=1 -> IF_ID_pc=0x20, PC_out=0x24.
REQ-042 Wrap and reset: PC_out=0xFFFF_FFFC, accepted fetch -> PC_out=0, IF_ID_pc_4=0; then reset with stall=1 and redirect=1 -> all outputs equal reset values.
